vga_pixel_source: RTL and testbench
===================================

Name: vga_pixel_source

Overview:
- Producer side of the per-pixel shading interface.
- Generates VGA raster timing and fetches one scanline of pixel attributes per line from the render/memory side into a ping-pong line buffer.
- Presents per-pixel blank, shadow/link/trans flags, link_color and tile_color to the final-colour stage, together with latency-matched hsync/vsync.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- PIX_DIV, 2, clk cycles per pixel (>=1)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- line_req  out  1  pulse (1 clk): request scanline line_y
- line_y  out  10  line number being requested
- fill_valid  in  1  fill word valid
- fill_ready  out  1  buffer accepts fill word
- fill_data  in  19  {b_trans, b_link, b_shadow, link_color[7:0], tile_color[7:0]}
- pix_ce  out  1  pixel strobe (1 clk every PIX_DIV clks)
- blank  out  1  1 outside active area
- b_shadow, b_link, b_trans  out  1 each  pixel flags
- link_color, tile_color  out  8 each  RGB332 colours
- hsync, vsync  out  1 each  active-low syncs
- underrun  out  1  sticky: a line started before its fill completed
- test_mode  in  1  only present with PIX_TEST_PATTERN_EN

Behaviour:
- Reset: blank=1, hsync=1, vsync=1, flags=0, colours=0, line_req=0, fill_ready=0, underrun=0, pix_ce=0. Counters h=0, v=0. Display bank=0.
- Reset mid-line or mid-fill aborts everything. Previously filled buffer contents are considered invalid, so line 0 is re-requested in the first frame.
- Pixel divider: counts 0..PIX_DIV-1. pix_ce=1 on terminal count. All timing advances only on pix_ce.
- h counts 0..H_TOTAL-1, where H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP. On wrap, v increments and wraps at V_TOTAL-1.
- Active region: h<H_ACTIVE and v<V_ACTIVE.
- Sync windows, both active low:
  - hsync low for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
  - vsync low for the analogous v window.
- Line requests:
  - On pix_ce with h==0, if v<V_ACTIVE-1: line_req pulses with line_y=v+1, targeting the non-display bank.
  - On pix_ce with h==0 and v==V_TOTAL-1: line_req pulses with line_y=0.
  - Fill write pointer resets to 0 and fill_ready rises on the same clk as line_req.
- Fill handshake:
  - A word transfers when fill_valid && fill_ready, and is written at the pointer, which then increments.
  - fill_ready drops the clk after the H_ACTIVE-th word. Extra words are not accepted.
  - fill_valid is allowed to go high before fill_ready; no word is lost.
- Bank swap: at pix_ce with h==H_TOTAL-1 on any line whose successor is active. If the fill is incomplete at that point:
  - underrun is set (sticky until rst).
  - The unfilled tail of that line displays as blank-colour 0.
  - The fill aborts and fill_ready drops.
- Buffer read: address=h, issued when h<H_ACTIVE.
- Pipeline latency is exactly 2 pix_ce from counter value to output.
- blank, hsync and vsync are delayed 2 pix_ce to stay aligned with the data.
- When blank=1, flags and colours are forced to 0.
- Outputs change only on clk edges where pix_ce is high, and are stable between strobes.

Optional Feature:
- Macro: PIX_TEST_PATTERN_EN.
- Defined: the test_mode port exists. When test_mode=1 during the active region:
  - tile_color = {h[8:6], v[8:6], h[5:4]}.
  - link_color = 0, all flags = 0.
  - Buffer contents are ignored.
  - line_req and fills continue normally.
- Undefined: no test_mode port; outputs always come from the buffer.

Test Plan:
- Reset, then run one frame with no fills → underrun=1 after line 0 starts. blank=0 only during 640x480, with all colours 0. hsync low 96 px, vsync low 2 lines; frame = 800x525 pixels.
- Fill each line with tile_color=h[7:0], link_color=~h[7:0], flags=3'b010 → at active pixel h, outputs tile_color=h[7:0], link=~h[7:0], b_link=1, 2 pix_ce after the counter.
- fill_valid held high with 700 words → exactly 640 accepted. fill_ready low afterwards until the next line_req.
- Fill stalls after 300 words on line 5 → underrun set. Pixels 300..639 of line 5 have colour 0. Line 6 displays correctly once filled.
- Assert rst at v=100, h=200 → next clk all outputs at reset values. The first line_req after restart is for line_y=0 at v=524, h=0.
- PIX_TEST_PATTERN_EN, test_mode=1, h=0x1F0, v=0x40 → tile_color=8'b111_001_11, flags 0.

Source files
------------

// File: rtl/vga_pixel_source.sv
// VGA raster timing plus ping-pong scanline buffer feeding the final-colour stage.
// Optional build macro PIX_TEST_PATTERN_EN adds the test_mode port and a generated tile pattern.
module vga_pixel_source #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int PIX_DIV  = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        line_req,
    output logic [9:0]  line_y,
    input  logic        fill_valid,
    output logic        fill_ready,
    input  logic [18:0] fill_data,
    output logic        pix_ce,
    output logic        blank,
    output logic        b_shadow,
    output logic        b_link,
    output logic        b_trans,
    output logic [7:0]  link_color,
    output logic [7:0]  tile_color,
    output logic        hsync,
    output logic        vsync,
    output logic        underrun
`ifdef PIX_TEST_PATTERN_EN
    ,
    input  logic        test_mode
`endif
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int AW      = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;

    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] HS_BEG   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] V_ACT_M1 = 10'(V_ACTIVE - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] VS_BEG   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [7:0] DIV_LAST = 8'(PIX_DIV - 1);

    logic [7:0]  div, div_nxt;
    logic [9:0]  h, v;
    logic [9:0]  wptr, wcnt_nxt, disp_cnt;
    logic        disp_bank, fill_bank, armed;
    logic        xfer, req_now, swap_now;
    logic [18:0] mem [2][H_ACTIVE];
    logic [18:0] pix_src, pix1;
    logic        act1, hs1, vs1;

    assign div_nxt = (div == DIV_LAST) ? 8'd0 : div + 8'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            div    <= '0;
            pix_ce <= 1'b0;
        end else begin
            div    <= div_nxt;
            pix_ce <= (div_nxt == DIV_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h <= '0;
            v <= '0;
        end else if (pix_ce) begin
            if (h == H_LAST) begin
                h <= '0;
                v <= (v == V_LAST) ? 10'd0 : v + 10'd1;
            end else begin
                h <= h + 10'd1;
            end
        end
    end

    // Until the line-0 request at the end of the first frame, the buffer holds
    // nothing trustworthy, so mid-frame requests stay suppressed.
    assign req_now  = pix_ce && (h == 10'd0) &&
                      (((v < V_ACT_M1) && armed) || (v == V_LAST));
    assign swap_now = pix_ce && (h == H_LAST) && ((v < V_ACT_M1) || (v == V_LAST));
    assign xfer     = fill_valid && fill_ready;
    assign wcnt_nxt = wptr + {9'd0, xfer};
    assign fill_bank = ~disp_bank;

    always_ff @(posedge clk) begin
        if (rst) begin
            line_req   <= 1'b0;
            line_y     <= '0;
            fill_ready <= 1'b0;
            wptr       <= '0;
            disp_bank  <= 1'b0;
            disp_cnt   <= '0;
            underrun   <= 1'b0;
            armed      <= 1'b0;
        end else begin
            line_req <= req_now;
            if (xfer) begin
                wptr <= wcnt_nxt;
                if (wcnt_nxt == H_ACT) fill_ready <= 1'b0;
            end
            // disp_cnt marks how much of the new display line is real data;
            // anything past it is shown as colour 0.
            if (swap_now) begin
                disp_bank <= ~disp_bank;
                disp_cnt  <= wcnt_nxt;
                wptr      <= '0;
                if (wcnt_nxt != H_ACT) begin
                    underrun   <= 1'b1;
                    fill_ready <= 1'b0;
                end
            end
            if (req_now) begin
                line_y     <= (v == V_LAST) ? 10'd0 : v + 10'd1;
                wptr       <= '0;
                fill_ready <= 1'b1;
                if (v == V_LAST) armed <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (xfer) mem[fill_bank][wptr[AW-1:0]] <= fill_data;
    end

    always_comb begin
        pix_src = '0;
        if (h < disp_cnt) pix_src = mem[disp_bank][h[AW-1:0]];
`ifdef PIX_TEST_PATTERN_EN
        if (test_mode) pix_src = {11'd0, h[8:6], v[8:6], h[5:4]};
`endif
    end

    // Two pix_ce stages: buffer read, then output register with blank gating.
    always_ff @(posedge clk) begin
        if (rst) begin
            act1       <= 1'b0;
            hs1        <= 1'b1;
            vs1        <= 1'b1;
            pix1       <= '0;
            blank      <= 1'b1;
            hsync      <= 1'b1;
            vsync      <= 1'b1;
            b_trans    <= 1'b0;
            b_link     <= 1'b0;
            b_shadow   <= 1'b0;
            link_color <= '0;
            tile_color <= '0;
        end else if (pix_ce) begin
            act1  <= (h < H_ACT) && (v < V_ACT);
            hs1   <= !((h >= HS_BEG) && (h < HS_END));
            vs1   <= !((v >= VS_BEG) && (v < VS_END));
            pix1  <= pix_src;
            blank <= !act1;
            hsync <= hs1;
            vsync <= vs1;
            {b_trans, b_link, b_shadow, link_color, tile_color} <= act1 ? pix1 : 19'd0;
        end
    end
endmodule

// File: tb/tb_vga_pixel_source.sv
// Directed bench for vga_pixel_source on a shrunken 25x13 raster, PIX_DIV=2.
module tb_vga_pixel_source;
    localparam int HA = 16, HF = 2, HS = 4, HB = 3;
    localparam int VA = 8, VF = 1, VS = 2, VB = 2;
    localparam int PD = 2;
    localparam int HT = HA + HF + HS + HB;    // 25
    localparam int VT = VA + VF + VS + VB;    // 13
    localparam int FRAME_PIX = HT * VT;       // 325
    localparam int FRAME_CLK = FRAME_PIX * PD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        line_req, fill_ready, pix_ce, blank, hsync, vsync, underrun;
    logic        b_shadow, b_link, b_trans;
    logic [9:0]  line_y;
    logic        fill_valid;
    logic [18:0] fill_data;
    logic [7:0]  link_color, tile_color;
    logic [21:0] obs;
`ifdef PIX_TEST_PATTERN_EN
    logic        test_mode = 1'b0;
`endif

    int n_chk = 0, n_fail = 0;
    int pix_n = 0;
    int got [VA];
    int cur = VA - 1, sent = 1000, lim;
    int fill_mode = 0, word_lim = HA, stall_line = -1, stall_at = 0;

    vga_pixel_source #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .PIX_DIV(PD)
    ) dut (
        .clk(clk), .rst(rst), .line_req(line_req), .line_y(line_y),
        .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_data(fill_data),
        .pix_ce(pix_ce), .blank(blank), .b_shadow(b_shadow), .b_link(b_link),
        .b_trans(b_trans), .link_color(link_color), .tile_color(tile_color),
        .hsync(hsync), .vsync(vsync), .underrun(underrun)
`ifdef PIX_TEST_PATTERN_EN
        , .test_mode(test_mode)
`endif
    );

    always #5 clk = ~clk;

    assign obs = {blank, hsync, vsync, b_trans, b_link, b_shadow, link_color, tile_color};

    function automatic logic [18:0] mk(int line, int w);
        logic [7:0] t;
        t = 8'(w + 16 * line);
        return {3'b010, ~t, t};
    endfunction

    // Expected output word while the raster counter sits on pixel index n.
    function automatic logic [21:0] exp_out(int n);
        int p, h, v;
        logic act, hs_e, vs_e;
        logic [7:0] t;
        if (n < 2) return {3'b111, 19'd0};
        p = n - 2; h = p % HT; v = (p / HT) % VT;
        act  = (h < HA) && (v < VA);
        hs_e = !((h >= HA + HF) && (h < HA + HF + HS));
        vs_e = !((v >= VA + VF) && (v < VA + VF + VS));
        if (act) begin
            if (h < got[v]) begin
                t = 8'(h + 16 * v);
                return {1'b0, hs_e, vs_e, 3'b010, ~t, t};
            end
        end
        return {!act, hs_e, vs_e, 19'd0};
    endfunction

    // Fill source and bookkeeping; runs on negedge so everything it reads is
    // what the next posedge will see.
    initial begin
        fill_valid = 1'b0;
        fill_data  = '0;
        for (int i = 0; i < VA; i++) got[i] = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pix_n = 0; cur = VA - 1; sent = 1000; fill_valid = 1'b0;
                for (int i = 0; i < VA; i++) got[i] = 0;
            end else begin
                if (line_req) begin cur = int'(line_y); sent = 0; got[cur] = 0; end
                lim = (cur == stall_line) ? stall_at : word_lim;
                if (fill_mode != 0 && sent < lim) begin
                    fill_valid = 1'b1; fill_data = mk(cur, sent);
                end else if (fill_mode == 2 && sent >= word_lim) begin
                    fill_valid = 1'b1; fill_data = mk((cur + 1) % VA, 0);
                end else begin
                    fill_valid = 1'b0;
                end
                if (fill_valid && fill_ready) begin sent++; got[cur]++; end
                if (pix_ce) pix_n++;
            end
        end
    end

    task automatic test_reset;
        int ones;
        fill_mode = 0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_chk++;
        if ({obs, line_req, fill_ready, underrun, pix_ce} !== {3'b111, 23'd0}) begin
            n_fail++;
            $display("FAIL reset_state got %h want %h", {obs, line_req, fill_ready, underrun, pix_ce}, {3'b111, 23'd0});
        end
        rst = 1'b0;
        ones = 0;
        repeat (FRAME_CLK) begin
            @(posedge clk); #1;
            if (pix_ce) ones++;
            n_chk++;
            if (obs !== exp_out(pix_n)) begin
                n_fail++;
                $display("FAIL nofill_pixel n=%0d got %h want %h", pix_n, obs, exp_out(pix_n));
            end
        end
        n_chk++;
        if (ones !== FRAME_PIX) begin
            n_fail++; $display("FAIL pix_ce_count got %0d want %0d", ones, FRAME_PIX);
        end
        n_chk++;
        if (underrun !== 1'b1) begin
            n_fail++; $display("FAIL underrun_nofill got %b want 1", underrun);
        end
    endtask

    task automatic test_fill_pattern;
        fill_mode = 2; word_lim = HA; stall_line = -1;
        repeat (2 * FRAME_CLK) begin
            @(posedge clk); #1;
            n_chk++;
            if (obs !== exp_out(pix_n)) begin
                n_fail++;
                $display("FAIL fill_pixel n=%0d got %h want %h", pix_n, obs, exp_out(pix_n));
            end
            // frame 3, v=3 h=5: tile 0x35, link 0xCA, b_link
            if (pix_n == 2 * FRAME_PIX + 3 * HT + 5 + 2) begin
                n_chk++;
                if ({blank, b_link, link_color, tile_color} !== {2'b01, 8'hCA, 8'h35}) begin
                    n_fail++;
                    $display("FAIL spot_v3h5 got %h want %h", {blank, b_link, link_color, tile_color}, {2'b01, 8'hCA, 8'h35});
                end
            end
        end
    endtask

    task automatic test_overflow;
        int c;
        logic ok;
        fill_mode = 1; word_lim = 20;
        for (c = 0; c < 2000 && !line_req; c++) begin @(posedge clk); #1; end
        for (c = 0; c < 100 && fill_ready; c++) begin @(posedge clk); #1; end
        n_chk++;
        if (got[cur] !== HA) begin
            n_fail++; $display("FAIL overflow_accepted got %0d want %0d", got[cur], HA);
        end
        ok = 1'b1;
        for (c = 0; c < 2000; c++) begin
            @(posedge clk); #1;
            if (line_req) break;
            if (fill_ready) ok = 1'b0;
        end
        n_chk++;
        if ({ok, line_req} !== 2'b11) begin
            n_fail++; $display("FAIL overflow_ready_low got %b want 11", {ok, line_req});
        end
        word_lim = HA;
    endtask

    task automatic test_underrun_stall;
        int p;
        fill_mode = 1; stall_line = 5; stall_at = 6;
        for (int c = 0; c < 2 * FRAME_CLK; c++) begin
            @(posedge clk); #1;
            n_chk++;
            if (obs !== exp_out(pix_n)) begin
                n_fail++;
                $display("FAIL stall_pixel n=%0d got %h want %h", pix_n, obs, exp_out(pix_n));
            end
            p = pix_n - 2;
            if (c > FRAME_CLK && (p % FRAME_PIX) == 5 * HT + 7) begin
                n_chk++;
                if ({blank, b_link, link_color, tile_color} !== 18'd0) begin
                    n_fail++; $display("FAIL stall_tail got %h want 0", {blank, b_link, link_color, tile_color});
                end
            end
            if (c > FRAME_CLK && (p % FRAME_PIX) == 6 * HT + 7) begin
                n_chk++;
                if ({blank, b_link, link_color, tile_color} !== {2'b01, 8'h98, 8'h67}) begin
                    n_fail++;
                    $display("FAIL stall_next_line got %h want %h", {blank, b_link, link_color, tile_color}, {2'b01, 8'h98, 8'h67});
                end
            end
        end
        n_chk++;
        if (underrun !== 1'b1) begin
            n_fail++; $display("FAIL underrun_stall got %b want 1", underrun);
        end
        stall_line = -1;
    endtask

    task automatic test_reset_restart;
        int c;
        fill_mode = 1;
        for (c = 0; c < 1000 && (pix_n % FRAME_PIX) != 3 * HT + 10; c++) begin @(posedge clk); #1; end
        n_chk++;
        if (c >= 1000) begin n_fail++; $display("FAIL restart_wait_pos timeout got %0d want <1000", c); end
        rst = 1'b1;
        @(posedge clk); #1;
        n_chk++;
        if ({obs, line_req, fill_ready, underrun, pix_ce} !== {3'b111, 23'd0}) begin
            n_fail++;
            $display("FAIL restart_state got %h want %h", {obs, line_req, fill_ready, underrun, pix_ce}, {3'b111, 23'd0});
        end
        rst = 1'b0;
        for (c = 0; c < 1000; c++) begin
            @(posedge clk); #1;
            if (line_req) break;
        end
        n_chk++;
        if ({line_req, line_y, 10'(pix_n)} !== {1'b1, 10'd0, 10'(VT * HT - HT + 1)}) begin
            n_fail++;
            $display("FAIL restart_first_req got req=%b y=%0d n=%0d want req=1 y=0 n=%0d", line_req, line_y, pix_n, VT * HT - HT + 1);
        end
    endtask

`ifdef PIX_TEST_PATTERN_EN
    function automatic logic [21:0] exp_pat(int n);
        int p;
        logic [9:0] h, v;
        logic act, hs_e, vs_e;
        p = n - 2; h = 10'(p % HT); v = 10'((p / HT) % VT);
        act  = (h < HA) && (v < VA);
        hs_e = !((h >= HA + HF) && (h < HA + HF + HS));
        vs_e = !((v >= VA + VF) && (v < VA + VF + VS));
        if (act) return {1'b0, hs_e, vs_e, 11'd0, h[8:6], v[8:6], h[5:4]};
        return {1'b1, hs_e, vs_e, 19'd0};
    endfunction

    task automatic test_pattern;
        test_mode = 1'b1;
        repeat (8) @(posedge clk);
        repeat (FRAME_CLK) begin
            @(posedge clk); #1;
            n_chk++;
            if (obs !== exp_pat(pix_n)) begin
                n_fail++; $display("FAIL pattern_pixel n=%0d got %h want %h", pix_n, obs, exp_pat(pix_n));
            end
        end
        test_mode = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_fill_pattern();
        test_overflow();
        test_underrun_stall();
        test_reset_restart();
`ifdef PIX_TEST_PATTERN_EN
        test_pattern();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
